// File: rtl/spi_arbiter_if.sv
// Requester-side and engine-side signals of the SPI engine arbiter.
// The arbiter uses the slave modport; the requesters/engine side uses master.
interface spi_arbiter_if;
  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] tx0;
  logic [7:0] tx1;
  logic       start0;
  logic       start1;
  logic       force_clock0;
  logic       force_clock1;
  logic       done0;
  logic       done1;
  logic [7:0] rx_data;
  logic [7:0] spi_data_tx;
  logic       spi_txn_start;
  logic       spi_force_clock;
  logic       spi_txn_done;
  logic [7:0] spi_data_rx;

  modport slave (
    input  req0, req1, tx0, tx1, start0, start1, force_clock0, force_clock1,
    input  spi_txn_done, spi_data_rx,
    output gnt0, gnt1, done0, done1, rx_data,
    output spi_data_tx, spi_txn_start, spi_force_clock
  );

  modport master (
    output req0, req1, tx0, tx1, start0, start1, force_clock0, force_clock1,
    output spi_txn_done, spi_data_rx,
    input  gnt0, gnt1, done0, done1, rx_data,
    input  spi_data_tx, spi_txn_start, spi_force_clock
  );
endinterface

// File: rtl/spi_arbiter.sv
// Grants the single SPI engine to one of two requesters, forwards only the
// owner's byte transactions and inserts a turnaround gap between owners.
module spi_arbiter #(
  parameter int TURNAROUND = 2
) (
  input logic        clk,
  input logic        rst,
  spi_arbiter_if.slave bus
);

  localparam int CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t        state;
  logic          busy;
  logic          last;
  logic [CW-1:0] gap_cnt;
  logic          own_req;
  logic          own_start;
  logic [7:0]    own_tx;
  logic          owner_free;

  assign own_req   = (state == OWN1) ? bus.req1   : bus.req0;
  assign own_start = (state == OWN1) ? bus.start1 : bus.start0;
  assign own_tx    = (state == OWN1) ? bus.tx1    : bus.tx0;

  // An owner finishing its transaction this cycle may release in the same cycle.
  assign owner_free = !busy || bus.spi_txn_done;

  assign bus.done0           = bus.gnt0 & busy & bus.spi_txn_done;
  assign bus.done1           = bus.gnt1 & busy & bus.spi_txn_done;
  assign bus.rx_data         = bus.spi_data_rx;
  assign bus.spi_force_clock = (bus.gnt0 & bus.force_clock0) | (bus.gnt1 & bus.force_clock1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      last              <= 1'b1;
      gap_cnt           <= '0;
      bus.gnt0          <= 1'b0;
      bus.gnt1          <= 1'b0;
      bus.spi_txn_start <= 1'b0;
      bus.spi_data_tx   <= 8'h00;
    end else begin
      bus.spi_txn_start <= 1'b0;
      case (state)
        IDLE: begin
          // On a tie the port that did not own the engine last wins.
          if (bus.req0 && (!bus.req1 || last)) begin
            state    <= OWN0;
            bus.gnt0 <= 1'b1;
          end else if (bus.req1) begin
            state    <= OWN1;
            bus.gnt1 <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (busy && bus.spi_txn_done) begin
            busy <= 1'b0;
          end
          if (!own_req && owner_free) begin
            last     <= (state == OWN1);
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            gap_cnt  <= '0;
            if (TURNAROUND == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end else if (own_start && !busy) begin
            bus.spi_data_tx   <= own_tx;
            bus.spi_txn_start <= 1'b1;
            busy              <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus pushes expected events (grant,
// force-clock, start pulse, done pulse) and a negedge monitor pops and compares.
module tb_spi_arbiter;

  localparam int K_GNT   = 0;
  localparam int K_FCLK  = 1;
  localparam int K_START = 2;
  localparam int K_DONE0 = 3;
  localparam int K_DONE1 = 4;

  typedef struct {
    int         kind;
    logic [7:0] val;
    int         at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic [1:0] prev_gnt = 2'b00;
  logic       prev_fclk = 1'b0;

  spi_arbiter_if a ();
  spi_arbiter_if z ();

  spi_arbiter #(.TURNAROUND(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  spi_arbiter #(.TURNAROUND(0)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (z.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(int k);
    case (k)
      K_GNT:   return "gnt";
      K_FCLK:  return "force_clock";
      K_START: return "txn_start";
      K_DONE0: return "done0";
      K_DONE1: return "done1";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_event(int kind, logic [7:0] val, int rel);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = base + rel;
    exp_q.push_back(e);
  endtask

  task automatic scoreboard_pop(int kind, logic [7:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_%s actual=%02h@%0d required=none",
               kind_name(kind), val, cyc - base);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.at != cyc) begin
        failures++;
        $display("[TB] FAIL %s actual=%s:%02h@%0d required=%s:%02h@%0d",
                 kind_name(e.kind), kind_name(kind), val, cyc - base,
                 kind_name(e.kind), e.val, e.at - base);
      end
    end
  endtask

  task automatic check_output(string name, logic [7:0] actual, logic [7:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%02h required=%02h", name, actual, required);
    end
  endtask

  // Monitor: every observable event on the TURNAROUND=2 instance goes through the scoreboard.
  always @(negedge clk) begin
    checks++;
    if (a.gnt0 === 1'b1 && a.gnt1 === 1'b1) begin
      failures++;
      $display("[TB] FAIL gnt_onehot actual=11 required=not_both at %0d", cyc - base);
    end
    if ({a.gnt1, a.gnt0} !== prev_gnt) scoreboard_pop(K_GNT, {6'b0, a.gnt1, a.gnt0});
    if (a.spi_force_clock !== prev_fclk) scoreboard_pop(K_FCLK, {7'b0, a.spi_force_clock});
    if (a.spi_txn_start === 1'b1) scoreboard_pop(K_START, a.spi_data_tx);
    if (a.done0 === 1'b1) scoreboard_pop(K_DONE0, a.rx_data);
    if (a.done1 === 1'b1) scoreboard_pop(K_DONE1, a.rx_data);
    prev_gnt  = {a.gnt1, a.gnt0};
    prev_fclk = a.spi_force_clock;
  end

  // Advance to #1 after the edge that starts relative cycle n.
  task automatic at(int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    a.req0 = 0; a.req1 = 0; a.tx0 = 8'h00; a.tx1 = 8'h00;
    a.start0 = 0; a.start1 = 0; a.force_clock0 = 0; a.force_clock1 = 0;
    a.spi_txn_done = 0; a.spi_data_rx = 8'h00;
    z.req0 = 0; z.req1 = 0; z.tx0 = 8'h00; z.tx1 = 8'h00;
    z.start0 = 0; z.start1 = 0; z.force_clock0 = 0; z.force_clock1 = 0;
    z.spi_txn_done = 0; z.spi_data_rx = 8'h00;
  endtask

  task automatic apply_stimulus();
    // Simple transfer, ignored starts, back-to-back, deferred release.
    at(0);  a.req0 = 1; a.force_clock1 = 1; expect_event(K_GNT, 8'h01, 1);
    at(2);  a.start0 = 1; a.tx0 = 8'h03; expect_event(K_START, 8'h03, 3);
    at(3);  a.tx0 = 8'h77;
    at(4);  a.start0 = 0; a.start1 = 1; a.tx1 = 8'hEE;
    at(5);  a.start1 = 0;
    at(6);  a.spi_txn_done = 1; a.spi_data_rx = 8'hA5; expect_event(K_DONE0, 8'hA5, 6);
    at(7);  a.spi_txn_done = 0; a.start0 = 1; a.tx0 = 8'h5A; expect_event(K_START, 8'h5A, 8);
    at(8);  a.start0 = 0;
    at(9);  a.req0 = 0; a.req1 = 1;
    at(11); a.spi_txn_done = 1; a.spi_data_rx = 8'h3C;
            expect_event(K_DONE0, 8'h3C, 11);
            expect_event(K_GNT, 8'h00, 12);
            expect_event(K_GNT, 8'h02, 15);
            expect_event(K_FCLK, 8'h01, 15);
    at(12); a.spi_txn_done = 0;
    at(14); a.spi_txn_done = 1; a.spi_data_rx = 8'hF0;
    at(15); a.spi_txn_done = 0;

    // Reset in the middle of port 1's transaction.
    at(16); a.start1 = 1; a.tx1 = 8'h9C; expect_event(K_START, 8'h9C, 17);
    at(17); a.start1 = 0;
    at(18); rst = 1; expect_event(K_GNT, 8'h00, 18); expect_event(K_FCLK, 8'h00, 18);
            #1;
            check_output("reset_txn_start", {7'b0, a.spi_txn_start}, 8'h00);
            check_output("reset_data_tx", a.spi_data_tx, 8'h00);
            check_output("reset_gnt", {6'b0, a.gnt1, a.gnt0}, 8'h00);
    at(19); a.spi_txn_done = 1; a.spi_data_rx = 8'h11;
    at(20); a.spi_txn_done = 0; rst = 0;
            expect_event(K_GNT, 8'h02, 21); expect_event(K_FCLK, 8'h01, 21);

    // Round-robin ties in both directions and force-clock gating for port 0.
    at(22); a.req1 = 0; expect_event(K_GNT, 8'h00, 23); expect_event(K_FCLK, 8'h00, 23);
    at(24); a.req0 = 1; a.req1 = 1; expect_event(K_GNT, 8'h01, 26);
    at(27); a.force_clock0 = 1; expect_event(K_FCLK, 8'h01, 27);
    at(28); a.force_clock0 = 0; a.req0 = 0;
            expect_event(K_FCLK, 8'h00, 28);
            expect_event(K_GNT, 8'h00, 29);
            expect_event(K_GNT, 8'h02, 32);
            expect_event(K_FCLK, 8'h01, 32);
    at(33); a.req1 = 0; expect_event(K_GNT, 8'h00, 34); expect_event(K_FCLK, 8'h00, 34);
    at(35); a.req0 = 1; a.req1 = 1; expect_event(K_GNT, 8'h01, 37);
    at(38); a.req0 = 0; expect_event(K_GNT, 8'h00, 39);
    at(39); a.req0 = 1; expect_event(K_GNT, 8'h02, 42); expect_event(K_FCLK, 8'h01, 42);

    // Release cancelled by re-asserting the request while busy.
    at(43); a.start1 = 1; a.tx1 = 8'h42; expect_event(K_START, 8'h42, 44);
    at(44); a.start1 = 0; a.req1 = 0;
    at(45); a.req1 = 1;
    at(46); a.spi_txn_done = 1; a.spi_data_rx = 8'h81; expect_event(K_DONE1, 8'h81, 46);
    at(47); a.spi_txn_done = 0;
    at(48); a.req0 = 0; a.req1 = 0;
            expect_event(K_GNT, 8'h00, 49); expect_event(K_FCLK, 8'h00, 49);

    // TURNAROUND = 0: next grant two cycles after the release sample.
    at(56); z.req0 = 1;
    at(57); check_output("z_gnt_after_req", {6'b0, z.gnt1, z.gnt0}, 8'h01);
    at(58); z.req0 = 0; z.req1 = 1; z.force_clock1 = 1;
    at(59); check_output("z_gnt_released", {6'b0, z.gnt1, z.gnt0}, 8'h00);
    at(60); check_output("z_gnt1_regrant", {6'b0, z.gnt1, z.gnt0}, 8'h02);
            check_output("z_force_clock", {7'b0, z.spi_force_clock}, 8'h01);
    at(64);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    base = cyc;
    apply_stimulus();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d_pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
